sprite_renderer: RTL and testbench

Downstream drawing stage for the game's motion controllers. Consumes the one-cycle `move` strobes and coordinates from the player, enemy and bullet controllers. Erases each sprite's previously drawn box and redraws it at its new position, one pixel per clock, into the VGA frame-buffer write port. Also clears the full 160x120 screen after reset and on every level load.

---
 rtl/game_pkg.sv | 27 ++
 rtl/sprite_renderer_if.sv | 37 +++
 rtl/box_scanner.sv | 50 +++++
 rtl/sprite_renderer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_sprite_renderer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared constants, ids and payload types for the game drawing pipeline.
package game_pkg;

  localparam int unsigned SCREEN_W     = 160;
  localparam int unsigned SCREEN_H     = 120;
  localparam int unsigned PLAYER_WIDTH = 3;
  localparam int unsigned BULLET_WIDTH = 1;

  localparam int unsigned X_W    = 8;  // screen x address
  localparam int unsigned Y_W    = 7;  // screen y address
  localparam int unsigned SIDE_W = 3;  // sprite side length
  localparam int unsigned COL_W  = 3;  // pixel colour
  localparam int unsigned SX_W   = 9;  // internal x, never wraps past a sprite edge
  localparam int unsigned SY_W   = 8;  // internal y, never wraps past a sprite edge

  typedef enum logic [1:0] {CLR, PLAYER, ENEMY, BULLET} client_e;
  typedef enum logic [1:0] {IDLE, CLEAR, ERASE, DRAW} state_e;

  // Position, size and colour of one sprite box.
  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [SIDE_W-1:0] w;
    logic [COL_W-1:0]  colour;
  } sprite_t;

endpackage

// File: rtl/sprite_renderer_if.sv
// Motion-controller strobes in, frame-buffer write port out.
interface sprite_renderer_if;
  import game_pkg::*;

  logic              load_level;
  logic              player_move;
  logic [X_W-1:0]    player_x;
  logic [Y_W-1:0]    player_y;
  logic              enemy_move;
  logic [X_W-1:0]    enemy_x;
  logic [Y_W-1:0]    enemy_y;
  logic [SIDE_W-1:0] enemy_width;
  logic [COL_W-1:0]  enemy_colour;
  logic              bullet_move;
  logic [X_W-1:0]    bullet_x;
  logic [Y_W-1:0]    bullet_y;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [COL_W-1:0]  colour;
  logic              plot;
  logic              busy;

  modport master (
    output load_level, player_move, player_x, player_y,
           enemy_move, enemy_x, enemy_y, enemy_width, enemy_colour,
           bullet_move, bullet_x, bullet_y,
    input  x, y, colour, plot, busy
  );

  modport slave (
    input  load_level, player_move, player_x, player_y,
           enemy_move, enemy_x, enemy_y, enemy_width, enemy_colour,
           bullet_move, bullet_x, bullet_y,
    output x, y, colour, plot, busy
  );

endinterface

// File: rtl/box_scanner.sv
// Row-major walk over a w x h box, one pixel per enabled cycle, with screen clipping.
module box_scanner
  import game_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            en,
  input  logic [SX_W-1:0] org_x,
  input  logic [SY_W-1:0] org_y,
  input  logic [SX_W-1:0] side_w,
  input  logic [SY_W-1:0] side_h,
  output logic [X_W-1:0]  x_c,
  output logic [Y_W-1:0]  y_c,
  output logic            in_bounds_c,
  output logic            done_c
);

  logic [SX_W-1:0] ox_q;
  logic [SY_W-1:0] oy_q;
  logic [SX_W-1:0] sum_x;
  logic [SY_W-1:0] sum_y;
  logic            last_col;
  logic            last_row;

  assign sum_x       = org_x + ox_q;
  assign sum_y       = org_y + oy_q;
  assign x_c         = X_W'(sum_x);
  assign y_c         = Y_W'(sum_y);
  assign in_bounds_c = (sum_x < SX_W'(SCREEN_W)) && (sum_y < SY_W'(SCREEN_H));
  assign last_col    = (ox_q == side_w - SX_W'(1));
  assign last_row    = (oy_q == side_h - SY_W'(1));
  assign done_c      = last_col && last_row;

  // Offset counters; wrap to the origin after the last pixel.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      ox_q <= '0;
      oy_q <= '0;
    end else if (en) begin
      if (last_col) begin
        ox_q <= '0;
        oy_q <= last_row ? '0 : oy_q + SY_W'(1);
      end else begin
        ox_q <= ox_q + SX_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_renderer.sv
// Erases and redraws sprite boxes and clears the screen through the frame-buffer write port.
module sprite_renderer
  import game_pkg::*;
#(
  parameter logic [COL_W-1:0] PLAYER_COLOUR = 3'b010,
  parameter logic [COL_W-1:0] BULLET_COLOUR = 3'b110,
  parameter logic [COL_W-1:0] BG_COLOUR     = 3'b000
) (
  input  logic             clk,
  input  logic             reset,
  sprite_renderer_if.slave bus
);

  state_e            state_q, state_d;
  logic [3:0]        pend_q, pend_d, pend_clr;
  logic [3:0]        drawn_q;
  logic [X_W-1:0]    last_x_q [4];
  logic [Y_W-1:0]    last_y_q [4];
  logic [SIDE_W-1:0] last_w_q [4];
  sprite_t           snap_q, cur;
  client_e           snap_id_q, gnt_id, commit_id;
  logic              gnt_valid, snap_ld, commit, commit_cur, clear_done, scan_start;

  logic [SX_W-1:0]   box_x, box_w;
  logic [SY_W-1:0]   box_y, box_h;
  logic [X_W-1:0]    sc_x;
  logic [Y_W-1:0]    sc_y;
  logic              sc_inb, sc_done, scan_en;

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [COL_W-1:0]  colour_q, colour_d;
  logic              plot_q, plot_d, busy_q, busy_d;

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;

  // Fixed-priority arbiter: clear > player > enemy > bullet.
  always_comb begin
    gnt_valid = 1'b1;
    gnt_id    = CLR;
    if      (pend_q[CLR])    gnt_id = CLR;
    else if (pend_q[PLAYER]) gnt_id = PLAYER;
    else if (pend_q[ENEMY])  gnt_id = ENEMY;
    else if (pend_q[BULLET]) gnt_id = BULLET;
    else                     gnt_valid = 1'b0;
  end

  // Live box of the client being granted.
  always_comb begin
    cur = '0;
    case (gnt_id)
      PLAYER: begin
        cur.x      = bus.player_x;
        cur.y      = bus.player_y;
        cur.w      = SIDE_W'(PLAYER_WIDTH);
        cur.colour = PLAYER_COLOUR;
      end
      ENEMY: begin
        cur.x      = bus.enemy_x;
        cur.y      = bus.enemy_y;
        cur.w      = bus.enemy_width;
        cur.colour = bus.enemy_colour;
      end
      BULLET: begin
        cur.x      = bus.bullet_x;
        cur.y      = bus.bullet_y;
        cur.w      = SIDE_W'(BULLET_WIDTH);
        cur.colour = BULLET_COLOUR;
      end
      default: ;
    endcase
  end

  // Box handed to the scanner for the current state.
  always_comb begin
    box_x = '0;
    box_y = '0;
    box_w = '0;
    box_h = '0;
    case (state_q)
      CLEAR: begin
        box_w = SX_W'(SCREEN_W);
        box_h = SY_W'(SCREEN_H);
      end
      ERASE: begin
        box_x = SX_W'(last_x_q[snap_id_q]);
        box_y = SY_W'(last_y_q[snap_id_q]);
        box_w = SX_W'(last_w_q[snap_id_q]);
        box_h = SY_W'(last_w_q[snap_id_q]);
      end
      DRAW: begin
        box_x = SX_W'(snap_q.x);
        box_y = SY_W'(snap_q.y);
        box_w = SX_W'(snap_q.w);
        box_h = SY_W'(snap_q.w);
      end
      default: ;
    endcase
  end

  assign scan_en = (state_q != IDLE);

  box_scanner u_scan (
    .clk         (clk),
    .reset       (reset),
    .start       (scan_start),
    .en          (scan_en),
    .org_x       (box_x),
    .org_y       (box_y),
    .side_w      (box_w),
    .side_h      (box_h),
    .x_c         (sc_x),
    .y_c         (sc_y),
    .in_bounds_c (sc_inb),
    .done_c      (sc_done)
  );

  // Next state, datapath strobes and next pixel outputs. Empty boxes are skipped.
  always_comb begin
    state_d    = state_q;
    pend_clr   = '0;
    scan_start = 1'b0;
    snap_ld    = 1'b0;
    commit     = 1'b0;
    commit_cur = 1'b0;
    commit_id  = snap_id_q;
    clear_done = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    plot_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          pend_clr[gnt_id] = 1'b1;
          if (gnt_id == CLR) begin
            state_d    = CLEAR;
            scan_start = 1'b1;
          end else begin
            snap_ld = 1'b1;
            if (drawn_q[gnt_id] && (last_w_q[gnt_id] != '0)) begin
              state_d    = ERASE;
              scan_start = 1'b1;
            end else if (cur.w != '0) begin
              state_d    = DRAW;
              scan_start = 1'b1;
            end else begin
              commit     = 1'b1;
              commit_cur = 1'b1;
              commit_id  = gnt_id;
            end
          end
        end
      end
      CLEAR: begin
        x_d      = sc_x;
        y_d      = sc_y;
        colour_d = BG_COLOUR;
        plot_d   = sc_inb;
        if (sc_done) begin
          state_d    = IDLE;
          clear_done = 1'b1;
        end
      end
      ERASE: begin
        x_d      = sc_x;
        y_d      = sc_y;
        colour_d = BG_COLOUR;
        plot_d   = sc_inb;
        if (sc_done) begin
          if (snap_q.w != '0) begin
            state_d    = DRAW;
            scan_start = 1'b1;
          end else begin
            state_d = IDLE;
            commit  = 1'b1;
          end
        end
      end
      DRAW: begin
        x_d      = sc_x;
        y_d      = sc_y;
        colour_d = snap_q.colour;
        plot_d   = sc_inb;
        if (sc_done) begin
          state_d = IDLE;
          commit  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || plot_d;
  end

  // Sticky request flags: grant clears, a coincident strobe wins.
  always_comb begin
    pend_d = pend_q & ~pend_clr;
    if (clear_done) begin
      pend_d[PLAYER] = 1'b1;
      pend_d[ENEMY]  = 1'b1;
      pend_d[BULLET] = 1'b1;
    end
    if (bus.load_level)  pend_d[CLR]    = 1'b1;
    if (bus.player_move) pend_d[PLAYER] = 1'b1;
    if (bus.enemy_move)  pend_d[ENEMY]  = 1'b1;
    if (bus.bullet_move) pend_d[BULLET] = 1'b1;
  end

  // State register and registered pixel port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
    end
  end

  // Pending flags, grant snapshot and last-drawn bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      pend_q[CLR] <= 1'b1;
      drawn_q     <= '0;
      snap_q      <= '0;
      snap_id_q   <= CLR;
      for (int i = 0; i < 4; i++) begin
        last_x_q[i] <= '0;
        last_y_q[i] <= '0;
        last_w_q[i] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      if (snap_ld) begin
        snap_q    <= cur;
        snap_id_q <= gnt_id;
      end
      if (clear_done) begin
        drawn_q <= '0;
        for (int i = 0; i < 4; i++) begin
          last_x_q[i] <= '0;
          last_y_q[i] <= '0;
          last_w_q[i] <= '0;
        end
      end else if (commit) begin
        last_x_q[commit_id] <= commit_cur ? cur.x : snap_q.x;
        last_y_q[commit_id] <= commit_cur ? cur.y : snap_q.y;
        last_w_q[commit_id] <= commit_cur ? cur.w : snap_q.w;
        drawn_q[commit_id]  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench: stimulus queues expected pixels, a monitor pops them on every plot.
module tb_sprite_renderer;
  import game_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sprite_renderer_if bus();

  sprite_renderer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   plot_cnt = 0;
  int   first_plot = -1;
  int   last_plot = -1;
  int   t0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every written pixel must be the next expected one.
  always @(negedge clk) begin
    if (bus.plot === 1'b1) begin
      plot_cnt++;
      if (first_plot < 0) first_plot = cyc;
      last_plot = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot cyc %0d got (%0d,%0d) c%0d required none",
                 cyc, bus.x, bus.y, bus.colour);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.x !== 8'(mon_e.x) || bus.y !== 7'(mon_e.y) || bus.colour !== 3'(mon_e.c)) begin
          errors++;
          $display("FAIL pixel cyc %0d got (%0d,%0d) c%0d required (%0d,%0d) c%0d",
                   cyc, bus.x, bus.y, bus.colour, mon_e.x, mon_e.y, mon_e.c);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_box(int x0, int y0, int w, int c);
    pix_t p;
    for (int yy = 0; yy < w; yy++)
      for (int xx = 0; xx < w; xx++)
        if (x0 + xx < 160 && y0 + yy < 120) begin
          p.x = x0 + xx;
          p.y = y0 + yy;
          p.c = c;
          exp_q.push_back(p);
        end
  endtask

  task automatic push_clear();
    pix_t p;
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++) begin
        p.x = xx;
        p.y = yy;
        p.c = 0;
        exp_q.push_back(p);
      end
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got %0d pixels outstanding required 0", name, exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic mark();
    t0 = cyc;
    plot_cnt = 0;
    first_plot = -1;
    last_plot = -1;
  endtask

  initial begin
    reset = 1'b1;
    bus.load_level   = 1'b0;
    bus.player_move  = 1'b0;
    bus.player_x     = 8'd80;
    bus.player_y     = 7'd115;
    bus.enemy_move   = 1'b0;
    bus.enemy_x      = 8'd20;
    bus.enemy_y      = 7'd10;
    bus.enemy_width  = 3'd4;
    bus.enemy_colour = 3'b101;
    bus.bullet_move  = 1'b0;
    bus.bullet_x     = 8'd50;
    bus.bullet_y     = 7'd100;

    // Reset values, then boot clear and first draw of every sprite.
    repeat (2) @(negedge clk);
    chk("rst_x", 32'(bus.x), 0);
    chk("rst_y", 32'(bus.y), 0);
    chk("rst_colour", 32'(bus.colour), 0);
    chk("rst_plot", 32'(bus.plot), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    push_clear();
    push_box(80, 115, 3, 2);
    push_box(20, 10, 4, 5);
    push_box(50, 100, 1, 6);
    reset = 1'b0;
    wait_cyc(cyc + 1);
    chk("boot_busy", 32'(bus.busy), 1);
    chk("boot_plot", 32'(bus.plot), 0);
    drain("boot", 20000);

    // Player move 80 -> 79 with latency checks.
    mark();
    bus.player_x = 8'd79;
    bus.player_move = 1'b1;
    push_box(80, 115, 3, 0);
    push_box(79, 115, 3, 2);
    wait_cyc(t0 + 1);
    bus.player_move = 1'b0;
    wait_cyc(t0 + 2);
    chk("lat_t2_plot", 32'(bus.plot), 0);
    wait_cyc(t0 + 3);
    chk("lat_t3_plot", 32'(bus.plot), 1);
    chk("lat_t3_x", 32'(bus.x), 80);
    wait_cyc(t0 + 20);
    chk("lat_t20_busy", 32'(bus.busy), 1);
    chk("lat_t20_plot", 32'(bus.plot), 1);
    wait_cyc(t0 + 21);
    chk("lat_t21_busy", 32'(bus.busy), 0);
    drain("player", 200);

    // Simultaneous strobes: player, enemy, bullet back to back.
    mark();
    bus.player_x = 8'd90;
    bus.enemy_x = 8'd30;
    bus.enemy_y = 7'd12;
    bus.bullet_x = 8'd60;
    bus.bullet_y = 7'd90;
    bus.player_move = 1'b1;
    bus.enemy_move = 1'b1;
    bus.bullet_move = 1'b1;
    push_box(79, 115, 3, 0);
    push_box(90, 115, 3, 2);
    push_box(20, 10, 4, 0);
    push_box(30, 12, 4, 5);
    push_box(50, 100, 1, 0);
    push_box(60, 90, 1, 6);
    wait_cyc(t0 + 1);
    bus.player_move = 1'b0;
    bus.enemy_move = 1'b0;
    bus.bullet_move = 1'b0;
    drain("simul", 300);
    chk("simul_plots", 32'(plot_cnt), 52);
    chk("simul_span", 32'(last_plot - first_plot + 1), 54);

    // Right-edge clipping: enemy w=4 at x=157.
    mark();
    bus.enemy_x = 8'd157;
    bus.enemy_y = 7'd40;
    bus.enemy_move = 1'b1;
    push_box(30, 12, 4, 0);
    push_box(157, 40, 4, 5);
    wait_cyc(t0 + 1);
    bus.enemy_move = 1'b0;
    drain("clip1", 200);
    chk("clip1_plots", 32'(plot_cnt), 28);
    mark();
    bus.enemy_y = 7'd50;
    bus.enemy_move = 1'b1;
    push_box(157, 40, 4, 0);
    push_box(157, 50, 4, 5);
    wait_cyc(t0 + 1);
    bus.enemy_move = 1'b0;
    drain("clip2", 200);
    chk("clip2_plots", 32'(plot_cnt), 24);
    chk("clip2_first", 32'(first_plot - t0), 3);
    chk("clip2_span", 32'(last_plot - first_plot), 30);

    // Coalescing: bullet to y=100, then two strobes during a player redraw.
    mark();
    bus.bullet_y = 7'd100;
    bus.bullet_move = 1'b1;
    push_box(60, 90, 1, 0);
    push_box(60, 100, 1, 6);
    wait_cyc(t0 + 1);
    bus.bullet_move = 1'b0;
    drain("bullet", 200);
    mark();
    bus.player_x = 8'd91;
    bus.player_move = 1'b1;
    push_box(90, 115, 3, 0);
    push_box(91, 115, 3, 2);
    push_box(60, 100, 1, 0);
    push_box(60, 98, 1, 6);
    wait_cyc(t0 + 1);
    bus.player_move = 1'b0;
    wait_cyc(t0 + 4);
    bus.bullet_y = 7'd99;
    bus.bullet_move = 1'b1;
    wait_cyc(t0 + 5);
    bus.bullet_move = 1'b0;
    wait_cyc(t0 + 9);
    bus.bullet_y = 7'd98;
    bus.bullet_move = 1'b1;
    wait_cyc(t0 + 10);
    bus.bullet_move = 1'b0;
    drain("coalesce", 300);
    chk("coalesce_plots", 32'(plot_cnt), 20);

    // Level load during enemy erase: enemy finishes, then clear and redraws.
    mark();
    bus.enemy_x = 8'd100;
    bus.enemy_y = 7'd50;
    bus.enemy_width = 3'd2;
    bus.enemy_colour = 3'b001;
    bus.enemy_move = 1'b1;
    push_box(157, 50, 4, 0);
    push_box(100, 50, 2, 1);
    push_clear();
    push_box(91, 115, 3, 2);
    push_box(100, 50, 2, 1);
    push_box(60, 98, 1, 6);
    wait_cyc(t0 + 1);
    bus.enemy_move = 1'b0;
    wait_cyc(t0 + 5);
    bus.load_level = 1'b1;
    wait_cyc(t0 + 6);
    bus.load_level = 1'b0;
    drain("level", 20000);

    // Reset in the middle of a player draw.
    mark();
    bus.player_x = 8'd92;
    bus.player_move = 1'b1;
    push_box(91, 115, 3, 0);
    for (int i = 0; i < 3; i++) begin
      pix_t p;
      p.x = 92 + i;
      p.y = 115;
      p.c = 2;
      exp_q.push_back(p);
    end
    wait_cyc(t0 + 1);
    bus.player_move = 1'b0;
    wait_cyc(t0 + 14);
    reset = 1'b1;
    wait_cyc(t0 + 15);
    chk("abort_plot", 32'(bus.plot), 0);
    chk("abort_outstanding", 32'(exp_q.size()), 0);
    push_clear();
    push_box(92, 115, 3, 2);
    push_box(100, 50, 2, 1);
    push_box(60, 98, 1, 6);
    wait_cyc(t0 + 16);
    reset = 1'b0;
    drain("post_reset", 20000);

    chk("final_outstanding", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
